// File: rtl/cond_unit_pipe.sv
// Condition unit: gates PC/register writes by ARM condition, keeps NZCV flags
// and an optional Thumb-style IT block sequencer (enable with COND_IT_EN).
module cond_unit_pipe #(
    parameter int NWE         = 3,
    parameter int FLAG_GROUPS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   InstrValid,
    input  logic                   Stall,
    input  logic                   Flush,
    input  logic [3:0]             Cond,
    input  logic [3:0]             ALUFlags,
    input  logic [FLAG_GROUPS-1:0] FlagW,
    input  logic                   PCS,
    input  logic [NWE-1:0]         WrEnIn,
    input  logic                   ITStart,
    input  logic [3:0]             ITCond,
    input  logic [2:0]             ITLen,
    input  logic [3:0]             ITThen,
    output logic                   PCSrc,
    output logic [NWE-1:0]         WrEnOut,
    output logic                   CondEx,
    output logic [3:0]             Flags,
    output logic                   ITActive
);

    localparam int GW = 4 / FLAG_GROUPS;

    logic       go;
    logic [3:0] eff_cond;
    logic       n, z, c, v;

    assign go = InstrValid & ~Stall & ~Flush;
    assign {n, z, c, v} = Flags;

    always_comb begin
        CondEx = 1'b0;
        case (eff_cond)
            4'b0000: CondEx = z;
            4'b0001: CondEx = ~z;
            4'b0010: CondEx = c;
            4'b0011: CondEx = ~c;
            4'b0100: CondEx = n;
            4'b0101: CondEx = ~n;
            4'b0110: CondEx = v;
            4'b0111: CondEx = ~v;
            4'b1000: CondEx = c & ~z;
            4'b1001: CondEx = ~c | z;
            4'b1010: CondEx = (n == v);
            4'b1011: CondEx = (n != v);
            4'b1100: CondEx = ~z & (n == v);
            4'b1101: CondEx = z | (n != v);
            default: CondEx = 1'b1;
        endcase
    end

    assign PCSrc   = PCS & CondEx & go;
    assign WrEnOut = WrEnIn & {NWE{CondEx & go}};

    always_ff @(posedge clk) begin
        if (reset) begin
            Flags <= 4'b0000;
        end else begin
            for (int g = 0; g < FLAG_GROUPS; g++) begin
                if (go && CondEx && FlagW[g])
                    Flags[g*GW +: GW] <= ALUFlags[g*GW +: GW];
            end
        end
    end

`ifdef COND_IT_EN
    typedef enum logic {IT_IDLE, IT_ACTIVE} it_state_t;

    it_state_t  state;
    logic [1:0] slot;
    logic [2:0] remaining;
    logic [3:0] it_cond;
    logic [3:0] it_then;
    logic       it_active_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IT_IDLE;
            slot        <= 2'd0;
            remaining   <= 3'd0;
            it_cond     <= 4'd0;
            it_then     <= 4'd0;
            it_active_q <= 1'b0;
        end else if (Flush) begin
            state       <= IT_IDLE;
            slot        <= 2'd0;
            remaining   <= 3'd0;
            it_active_q <= 1'b0;
        end else if (go) begin
            case (state)
                IT_IDLE: begin
                    if (ITStart && ITLen != 3'd0) begin
                        state       <= IT_ACTIVE;
                        it_active_q <= 1'b1;
                        it_cond     <= ITCond;
                        it_then     <= ITThen;
                        slot        <= 2'd0;
                        remaining   <= (ITLen > 3'd4) ? 3'd4 : ITLen;
                    end
                end
                IT_ACTIVE: begin
                    // ITStart is deliberately ignored while a block runs
                    slot      <= slot + 2'd1;
                    remaining <= remaining - 3'd1;
                    if (remaining == 3'd1) begin
                        state       <= IT_IDLE;
                        it_active_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IT_IDLE;
                    it_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign ITActive = it_active_q;
    assign eff_cond = !it_active_q ? Cond
                    : it_then[slot] ? it_cond
                    : {it_cond[3:1], ~it_cond[0]};
`else
    logic unused_it;

    assign unused_it = ^{ITStart, ITCond, ITLen, ITThen};
    assign ITActive  = 1'b0;
    assign eff_cond  = Cond;
`endif

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Directed bench for cond_unit_pipe with a queue-based reference model.
// IT-block vectors are exercised only when COND_IT_EN is defined.
module tb_cond_unit_pipe;

    localparam int NWE = 3;
    localparam int FG  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           valid, stall, flush, pcs;
    logic [3:0]     cond, alu;
    logic [FG-1:0]  flagw;
    logic [NWE-1:0] wren;
    logic           its;
    logic [3:0]     itc, itt;
    logic [2:0]     itl;
    logic           pcsrc, condex, itact;
    logic [NWE-1:0] wrout;
    logic [3:0]     flags;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    cond_unit_pipe #(.NWE(NWE), .FLAG_GROUPS(FG)) dut (
        .clk(clk), .reset(reset), .InstrValid(valid), .Stall(stall),
        .Flush(flush), .Cond(cond), .ALUFlags(alu), .FlagW(flagw),
        .PCS(pcs), .WrEnIn(wren), .ITStart(its), .ITCond(itc),
        .ITLen(itl), .ITThen(itt), .PCSrc(pcsrc), .WrEnOut(wrout),
        .CondEx(condex), .Flags(flags), .ITActive(itact)
    );

    always #5 clk = ~clk;

    // reference model: flags plus a queue of pending IT-slot conditions
    logic [3:0] m_flags;
    logic [3:0] it_q[$];

    function automatic logic passes(input logic [3:0] cc, input logic [3:0] f);
        logic r;
        case (cc[3:1])
            3'd0: r = f[2];
            3'd1: r = f[1];
            3'd2: r = f[3];
            3'd3: r = f[0];
            3'd4: r = f[1] && !f[2];
            3'd5: r = (f[3] == f[0]);
            3'd6: r = (f[3] == f[0]) && !f[2];
            default: r = 1'b1;
        endcase
        if (cc[0] && cc != 4'hF) r = !r;
        return r;
    endfunction

    function automatic logic m_ce();
        return passes(it_q.size() != 0 ? it_q[0] : cond, m_flags);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic go, ce;
        go = valid && !stall && !flush;
        ce = m_ce();
        if (reset) begin
            m_flags = 4'b0000;
            it_q.delete();
        end else begin
            if (go && ce)
                for (int b = 0; b < 4; b++)
                    if (flagw[b / (4 / FG)]) m_flags[b] = alu[b];
`ifdef COND_IT_EN
            if (flush) it_q.delete();
            else if (go) begin
                if (it_q.size() != 0) void'(it_q.pop_front());
                else if (its && itl != 0)
                    for (int i = 0; i < ((itl > 4) ? 4 : int'(itl)); i++)
                        it_q.push_back(itt[i] ? itc : {itc[3:1], ~itc[0]});
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            logic go, ce;
            go = valid && !stall && !flush;
            ce = m_ce();
            check("condex", condex, ce);
            check("pcsrc", pcsrc, pcs && ce && go);
            check("wrenout", wrout, (ce && go) ? wren : '0);
            check("flags", flags, m_flags);
            check("itactive", itact, it_q.size() != 0);
        end
    end

    task automatic opx(input logic v, st, fl, input logic [3:0] c, a,
                       input logic [FG-1:0] fw, input logic p,
                       input logic [NWE-1:0] we, input logic s,
                       input logic [3:0] ic, input logic [2:0] il,
                       input logic [3:0] it);
        @(posedge clk);
        #1;
        valid = v; stall = st; flush = fl; cond = c; alu = a;
        flagw = fw; pcs = p; wren = we;
        its = s; itc = ic; itl = il; itt = it;
        #3;
    endtask

    task automatic op(input logic v, input logic [3:0] c,
                      input logic [FG-1:0] fw, input logic [3:0] a,
                      input logic p, input logic [NWE-1:0] we);
        opx(v, 0, 0, c, a, fw, p, we, 0, 4'h0, 3'd0, 4'h0);
    endtask

    task automatic itstart(input logic [3:0] ic, input logic [2:0] il,
                           input logic [3:0] it);
        opx(1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 3'b000, 1, ic, il, it);
    endtask

    localparam logic [3:0] EQ = 4'h0, NE = 4'h1, GE = 4'hA, LT = 4'hB,
                           AL = 4'hE;

    logic [3:0] fvals [8] = '{4'h0, 4'h4, 4'h2, 4'h9, 4'h6, 4'h8, 4'h1, 4'hD};

    initial begin
        reset = 1; valid = 0; stall = 0; flush = 0; cond = AL; alu = 0;
        flagw = 0; pcs = 0; wren = 0; its = 0; itc = 0; itl = 0; itt = 0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        op(1, AL, 2'b11, 4'hF, 1, 3'b111);
        check("reset_wren_not_gated", wrout, 3'b111);
        check("reset_pcsrc_not_gated", pcsrc, 1);
        op(0, AL, 2'b00, 4'h0, 1, 3'b111);
        check("reset_flags", flags, 4'h0);
        check("reset_bubble_pcsrc", pcsrc, 0);
        reset = 0;

        op(1, EQ, 2'b00, 4'h0, 0, 3'b111);
        check("eq_after_reset", wrout, 3'b000);
        op(1, AL, 2'b01, 4'h4, 0, 3'b000);
        op(1, AL, 2'b10, 4'h4, 0, 3'b000);
        check("group0_no_change", flags, 4'h0);
        op(1, EQ, 2'b00, 4'h0, 0, 3'b101);
        check("group1_flags", flags, 4'h4);
        check("eq_pass", condex, 1);
        check("eq_wren", wrout, 3'b101);
        op(1, NE, 2'b11, 4'hB, 0, 3'b111);
        op(1, EQ, 2'b11, 4'h9, 0, 3'b000);
        check("failed_cond_no_flags", flags, 4'h4);
        op(1, GE, 2'b00, 4'h0, 0, 3'b000);
        check("ge_nv_equal", condex, 1);
        op(1, LT, 2'b00, 4'h0, 0, 3'b000);
        check("lt_nv_equal", condex, 0);

        opx(1, 1, 0, AL, 4'h0, 2'b11, 1, 3'b111, 0, 0, 0, 0);
        check("stall_pcsrc", pcsrc, 0);
        opx(1, 1, 0, AL, 4'h0, 2'b11, 1, 3'b111, 0, 0, 0, 0);
        op(1, AL, 2'b00, 4'h0, 1, 3'b000);
        check("stall_flags", flags, 4'h9);
        check("release_pcsrc", pcsrc, 1);
        op(1, AL, 2'b00, 4'h0, 0, 3'b000);
        check("pcsrc_one_cycle", pcsrc, 0);
        op(0, AL, 2'b11, 4'h0, 1, 3'b111);
        opx(1, 0, 1, AL, 4'h0, 2'b11, 1, 3'b111, 0, 0, 0, 0);
        op(1, AL, 2'b00, 4'h0, 0, 3'b000);
        check("bubble_flush_flags", flags, 4'h9);

        foreach (fvals[k]) begin
            op(1, AL, 2'b11, fvals[k], 0, 3'b000);
            for (int cc = 0; cc < 16; cc++)
                op(1, 4'(cc), 2'b00, 4'h0, 1, 3'(cc + k));
        end

        op(1, AL, 2'b11, 4'h4, 0, 3'b000);
`ifdef COND_IT_EN
        itstart(EQ, 3'd3, 4'b0101);
        check("it_instr_idle", itact, 0);
        op(1, NE, 2'b00, 4'h0, 0, 3'b111);
        check("it_slot0", condex, 1);
        check("it_active", itact, 1);
        op(1, NE, 2'b00, 4'h0, 0, 3'b111);
        check("it_slot1", condex, 0);
        op(1, NE, 2'b00, 4'h0, 0, 3'b111);
        check("it_slot2", condex, 1);
        op(1, NE, 2'b00, 4'h0, 0, 3'b111);
        check("it_done", itact, 0);
        check("it_done_cond", condex, 0);

        itstart(EQ, 3'd2, 4'b0010);
        opx(1, 1, 0, AL, 4'h0, 2'b00, 1, 3'b111, 0, 0, 0, 0);
        check("it_stall_slot0", condex, 0);
        opx(1, 0, 0, AL, 4'h0, 2'b00, 1, 3'b111, 1, NE, 3'd4, 4'hF);
        check("it_after_stall", condex, 0);
        opx(0, 0, 0, AL, 4'h0, 2'b00, 1, 3'b111, 0, 0, 0, 0);
        op(1, NE, 2'b00, 4'h0, 1, 3'b111);
        check("it_bubble_hold", condex, 1);
        op(1, NE, 2'b00, 4'h0, 1, 3'b111);
        check("it_restart_ignored", itact, 0);

        itstart(EQ, 3'd0, 4'hF);
        op(1, NE, 2'b00, 4'h0, 0, 3'b000);
        check("itlen0_noop", itact, 0);
        itstart(EQ, 3'd7, 4'hF);
        repeat (4) op(1, NE, 2'b00, 4'h0, 0, 3'b001);
        op(1, NE, 2'b00, 4'h0, 0, 3'b001);
        check("itlen7_clamped", itact, 0);

        itstart(EQ, 3'd4, 4'hF);
        op(1, NE, 2'b00, 4'h0, 0, 3'b000);
        opx(1, 0, 1, NE, 4'h0, 2'b00, 1, 3'b111, 0, 0, 0, 0);
        check("flush_suppress", wrout, 3'b000);
        op(1, NE, 2'b00, 4'h0, 0, 3'b111);
        check("flush_idle", itact, 0);
        check("flush_cond", condex, 0);

        itstart(EQ, 3'd4, 4'hF);
        opx(1, 1, 1, AL, 4'h0, 2'b00, 1, 3'b111, 0, 0, 0, 0);
        op(1, NE, 2'b00, 4'h0, 0, 3'b000);
        check("stall_flush_idle", itact, 0);
`else
        itstart(EQ, 3'd3, 4'b0101);
        op(1, NE, 2'b00, 4'h0, 0, 3'b111);
        check("no_it_inactive", itact, 0);
        check("no_it_cond", condex, 0);
`endif
        op(0, AL, 2'b00, 4'h0, 0, 3'b000);
        @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
